// File: rtl/lfsr_checker_if.sv
// ============================================================================
// Module   : lfsr_checker_if
// Brief    : Sample/monitor bundle between an LFSR source and lfsr_checker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lfsr_checker_if;
  logic       in_valid;
  logic [3:0] din;
  logic       clr;
  logic       locked;
  logic       err;
  logic [7:0] err_count;
  logic [4:0] period;
  logic       period_valid;
  logic       stuck;

  modport master (
    output in_valid, din, clr,
    input  locked, err, err_count, period, period_valid, stuck
  );

  modport slave (
    input  in_valid, din, clr,
    output locked, err, err_count, period, period_valid, stuck
  );
endinterface

`default_nettype wire

// File: rtl/lfsr_checker.sv
// ============================================================================
// Module   : lfsr_checker
// Brief    : Predicts a 4-bit LFSR stream, locks on it, measures its period
//            and counts mismatches once locked.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr_checker #(
  parameter int unsigned LOCK_COUNT = 3
) (
  input  wire logic     clk,
  input  wire logic     rst,
  lfsr_checker_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACQ  = 2'd1,
    S_LOCK = 2'd2
  } state_t;

  localparam logic [3:0] c_LOCK_CNT  = LOCK_COUNT[3:0];
  localparam logic [4:0] c_STEP_MAX  = 5'd31;
  localparam logic [7:0] c_CNT_MAX   = 8'd255;

  function automatic logic [3:0] lfsr_next(input logic [3:0] s);
    return {s[0] ^ s[1], s[3], s[2], s[1]};
  endfunction

  state_t     r_state,        w_state_nxt;
  logic [3:0] r_expected,     w_expected_nxt;
  logic [3:0] r_match_cnt,    w_match_cnt_nxt;
  logic [3:0] r_anchor,       w_anchor_nxt;
  logic [4:0] r_step,         w_step_nxt;
  logic [4:0] r_period,       w_period_nxt;
  logic       r_period_valid, w_period_valid_nxt;
  logic       r_err,          w_err_nxt;
  logic [7:0] r_err_count,    w_err_count_nxt;
  logic       r_stuck,        w_stuck_nxt;
  logic       r_locked;

  logic       w_set_stuck;
  logic       w_lock_miss;
  logic [3:0] w_cnt_inc;
  logic [3:0] w_din_next;

  assign w_cnt_inc  = r_match_cnt + 4'd1;
  assign w_din_next = lfsr_next(bus.din);

  always_comb begin
    w_state_nxt        = r_state;
    w_expected_nxt     = r_expected;
    w_match_cnt_nxt    = r_match_cnt;
    w_anchor_nxt       = r_anchor;
    w_step_nxt         = r_step;
    w_period_nxt       = r_period;
    w_period_valid_nxt = 1'b0;
    w_err_nxt          = 1'b0;
    w_set_stuck        = 1'b0;
    w_lock_miss        = 1'b0;

    if (bus.in_valid) begin
      case (r_state)
        S_IDLE: begin
          if (bus.din == 4'd0) begin
            w_set_stuck = 1'b1;
          end else begin
            w_expected_nxt  = w_din_next;
            w_match_cnt_nxt = 4'd0;
            w_state_nxt     = S_ACQ;
          end
        end

        S_ACQ: begin
          if (bus.din == r_expected) begin
            w_match_cnt_nxt = w_cnt_inc;
            w_expected_nxt  = w_din_next;
            if (w_cnt_inc == c_LOCK_CNT) begin
              w_state_nxt  = S_LOCK;
              w_anchor_nxt = bus.din;
              w_step_nxt   = 5'd0;
            end
          end else if (bus.din != 4'd0) begin
            w_expected_nxt  = w_din_next;
            w_match_cnt_nxt = 4'd0;
          end else begin
            w_set_stuck = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end

        S_LOCK: begin
          if (bus.din == r_expected) begin
            w_expected_nxt = w_din_next;
            if (bus.din == r_anchor) begin
              // A saturated step means the anchor took too long; report the cap.
              w_period_nxt       = (r_step == c_STEP_MAX) ? c_STEP_MAX : r_step + 5'd1;
              w_period_valid_nxt = 1'b1;
              w_step_nxt         = 5'd0;
            end else if (r_step != c_STEP_MAX) begin
              w_step_nxt = r_step + 5'd1;
            end
          end else begin
            w_err_nxt   = 1'b1;
            w_lock_miss = 1'b1;
            if (bus.din != 4'd0) begin
              w_expected_nxt  = w_din_next;
              w_match_cnt_nxt = 4'd0;
              w_state_nxt     = S_ACQ;
            end else begin
              w_set_stuck = 1'b1;
              w_state_nxt = S_IDLE;
            end
          end
        end

        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end

    w_err_count_nxt = r_err_count;
    if (bus.clr) begin
      w_err_count_nxt = 8'd0;
    end else if (w_lock_miss && (r_err_count != c_CNT_MAX)) begin
      w_err_count_nxt = r_err_count + 8'd1;
    end

    // A zero sample wins over a same-cycle clear so the lockup is never missed.
    w_stuck_nxt = r_stuck;
    if (w_set_stuck) begin
      w_stuck_nxt = 1'b1;
    end else if (bus.clr) begin
      w_stuck_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_expected     <= 4'd0;
      r_match_cnt    <= 4'd0;
      r_anchor       <= 4'd0;
      r_step         <= 5'd0;
      r_period       <= 5'd0;
      r_period_valid <= 1'b0;
      r_err          <= 1'b0;
      r_err_count    <= 8'd0;
      r_stuck        <= 1'b0;
      r_locked       <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_expected     <= w_expected_nxt;
      r_match_cnt    <= w_match_cnt_nxt;
      r_anchor       <= w_anchor_nxt;
      r_step         <= w_step_nxt;
      r_period       <= w_period_nxt;
      r_period_valid <= w_period_valid_nxt;
      r_err          <= w_err_nxt;
      r_err_count    <= w_err_count_nxt;
      r_stuck        <= w_stuck_nxt;
      r_locked       <= (w_state_nxt == S_LOCK);
    end
  end

  assign bus.locked       = r_locked;
  assign bus.err          = r_err;
  assign bus.err_count    = r_err_count;
  assign bus.period       = r_period;
  assign bus.period_valid = r_period_valid;
  assign bus.stuck        = r_stuck;

endmodule

`default_nettype wire

// File: tb/tb_lfsr_checker.sv
// ============================================================================
// Module   : tb_lfsr_checker
// Brief    : Directed self-checking bench for lfsr_checker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lfsr_checker;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  lfsr_checker_if bus ();

  lfsr_checker #(.LOCK_COUNT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] seq [15] = '{4'h8, 4'h4, 4'h2, 4'h9, 4'hC, 4'h6, 4'hB, 4'h5,
                           4'hA, 4'hD, 4'hE, 4'hF, 4'h7, 4'h3, 4'h1};

  function automatic logic [3:0] nx(input logic [3:0] s);
    return {s[0] ^ s[1], s[3], s[2], s[1]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs and return 1 ns after the sampling edge.
  task automatic send(input logic v, input logic [3:0] d, input logic c = 1'b0);
    bus.in_valid = v;
    bus.din      = d;
    bus.clr      = c;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.clr      = 1'b0;
  endtask

  initial begin
    logic [3:0] cur;
    logic [3:0] s;
    logic [3:0] w;
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.din      = 4'h0;
    bus.clr      = 1'b0;

    #12;
    chk("rst_locked", bus.locked, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_err_count", bus.err_count, 0);
    chk("rst_period", bus.period, 0);
    chk("rst_period_valid", bus.period_valid, 0);
    chk("rst_stuck", bus.stuck, 0);
    rst = 1'b0;

    // Acquire and measure period on a continuous stream.
    for (int i = 0; i < 4; i++) begin
      send(1'b1, seq[i]);
      chk("acq_locked", bus.locked, (i == 3) ? 1 : 0);
      chk("acq_err", bus.err, 0);
    end
    for (int i = 1; i <= 30; i++) begin
      send(1'b1, seq[(3 + i) % 15]);
      chk("run_pv", bus.period_valid, (i % 15 == 0) ? 1 : 0);
      chk("run_err", bus.err, 0);
      if (i % 15 == 0) chk("run_period", bus.period, 15);
    end

    // Inject 5 where 4 is expected, then relock from 5.
    for (int i = 4; i < 15; i++) send(1'b1, seq[i]);
    send(1'b1, seq[0]);
    send(1'b1, 4'h5);
    chk("miss_err", bus.err, 1);
    chk("miss_err_count", bus.err_count, 1);
    chk("miss_locked", bus.locked, 0);
    send(1'b1, 4'hA);
    chk("miss_err_once", bus.err, 0);
    chk("relock_a", bus.locked, 0);
    send(1'b1, 4'hD);
    chk("relock_d", bus.locked, 0);
    send(1'b1, 4'hE);
    chk("relock_e", bus.locked, 1);

    // Zero sample in LOCK and in IDLE, then clear.
    send(1'b1, 4'h0);
    chk("z_lock_err", bus.err, 1);
    chk("z_lock_err_count", bus.err_count, 2);
    chk("z_lock_stuck", bus.stuck, 1);
    chk("z_lock_locked", bus.locked, 0);
    send(1'b1, 4'h0);
    chk("z_idle_err", bus.err, 0);
    chk("z_idle_err_count", bus.err_count, 2);
    chk("z_idle_stuck", bus.stuck, 1);
    send(1'b0, 4'h0, 1'b1);
    chk("clr_stuck", bus.stuck, 0);
    chk("clr_err_count", bus.err_count, 0);
    send(1'b1, 4'h0);
    chk("z_idle2_stuck", bus.stuck, 1);
    send(1'b1, 4'h0, 1'b1);
    chk("clr_vs_zero_stuck", bus.stuck, 1);
    send(1'b0, 4'h0, 1'b1);
    chk("clr2_stuck", bus.stuck, 0);

    // Same stream with in_valid toggling; invalid cycles carry a zero din.
    for (int i = 0; i < 19; i++) begin
      send(1'b1, seq[i % 15]);
      chk("gap_locked", bus.locked, (i >= 3) ? 1 : 0);
      chk("gap_pv", bus.period_valid, (i == 18) ? 1 : 0);
      if (i == 18) chk("gap_period", bus.period, 15);
      send(1'b0, 4'h0);
      chk("gap_idle_pv", bus.period_valid, 0);
      chk("gap_idle_err", bus.err, 0);
      chk("gap_idle_stuck", bus.stuck, 0);
      chk("gap_idle_locked", bus.locked, (i >= 3) ? 1 : 0);
    end

    // 256 mismatches with relocks in between.
    send(1'b0, 4'h0, 1'b1);
    chk("sat_clr", bus.err_count, 0);
    cur = 4'h9;
    for (int k = 0; k < 256; k++) begin
      w = nx(nx(cur));
      send(1'b1, w);
      chk("sat_err", bus.err, 1);
      chk("sat_count", bus.err_count, (k + 1 > 255) ? 255 : k + 1);
      s = w;
      for (int j = 0; j < 3; j++) begin
        s = nx(s);
        send(1'b1, s);
      end
      chk("sat_relock", bus.locked, 1);
      cur = s;
    end
    chk("sat_final", bus.err_count, 255);

    w = nx(nx(cur));
    send(1'b1, w, 1'b1);
    chk("clr_miss_err", bus.err, 1);
    chk("clr_miss_count", bus.err_count, 0);
    s = w;
    for (int j = 0; j < 3; j++) begin
      s = nx(s);
      send(1'b1, s);
    end
    chk("clr_miss_relock", bus.locked, 1);
    w = nx(nx(s));
    send(1'b1, w);
    chk("pre_rst_count", bus.err_count, 1);
    s = w;
    for (int j = 0; j < 3; j++) begin
      s = nx(s);
      send(1'b1, s);
    end
    chk("pre_rst_locked", bus.locked, 1);

    // Asynchronous reset between edges.
    #2;
    rst = 1'b1;
    #1;
    chk("arst_locked", bus.locked, 0);
    chk("arst_err", bus.err, 0);
    chk("arst_err_count", bus.err_count, 0);
    chk("arst_period", bus.period, 0);
    chk("arst_period_valid", bus.period_valid, 0);
    chk("arst_stuck", bus.stuck, 0);
    #1;
    rst = 1'b0;

    send(1'b1, 4'h1);
    chk("restart_1", bus.locked, 0);
    send(1'b1, 4'h8);
    chk("restart_8", bus.locked, 0);
    send(1'b1, 4'h4);
    chk("restart_4", bus.locked, 0);
    send(1'b1, 4'h2);
    chk("restart_2", bus.locked, 1);
    chk("restart_err", bus.err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lfsr_checker.md
# lfsr_checker

Downstream consumer of the 4-bit LFSR stage. It samples the generator's parallel output and predicts each next value from the generator's recurrence. It acquires lock after a run of correct predictions, then measures the sequence period and counts mismatches. It is the self-check and monitor stage for the pseudo-random source in the lab designs.

## Interface
- LOCK_COUNT, 3: consecutive correct predictions needed to enter LOCK (1..15).
- clk  input  1  sole clock; all state updates on posedge.
- rst  input  1  reset; asynchronous, active-high; clears all state immediately.
- in_valid  input  1  din is a new LFSR sample this cycle.
- din  input  4  LFSR output sample.
- clr  input  1  synchronous clear of err_count and stuck.
- locked  output  1  level; high while in LOCK.
- err  output  1  one-cycle pulse on a mismatch while in LOCK.
- err_count  output  8  saturating mismatch count; holds at 255.
- period  output  5  last measured period in valid samples.
- period_valid  output  1  one-cycle pulse when period updates.
- stuck  output  1  sticky; set when din == 0 is sampled.

## Operation
- Recurrence: next(s) = {s[0]^s[1], s[3], s[2], s[1]}. For nonzero s this has period 15; the all-zero state is a lockup state.
- Internal registers:
  - state: IDLE/ACQ/LOCK.
  - expected[3:0]
  - match_cnt[3:0]
  - anchor[3:0]
  - step[4:0]
- No change occurs on cycles with in_valid = 0, except for clr.
- IDLE, on a valid sample:
  - din == 0: set stuck, stay in IDLE.
  - Otherwise: expected <= next(din), match_cnt <= 0, go to ACQ.
- ACQ, on a valid sample:
  - din == expected: match_cnt increments and expected <= next(din).
  - If match_cnt+1 == LOCK_COUNT: go to LOCK, with anchor <= din and step <= 0.
  - Mismatch with din != 0: reseed, i.e. expected <= next(din) and match_cnt <= 0; stay in ACQ.
  - Mismatch with din == 0: set stuck, go to IDLE.
  - No err pulses are raised in ACQ.
- LOCK, on a valid sample:
  - Match: expected <= next(din).
    - If din == anchor: period <= step+1, pulse period_valid, step <= 0.
    - Otherwise: step <= step+1.
  - Mismatch: pulse err and increment err_count (saturating at 255). Leave LOCK.
    - din != 0: reseed and go to ACQ.
    - din == 0: set stuck, go to IDLE.
- step saturates at 31. If the anchor never recurs, period is not updated.
- clr has priority over a same-cycle err_count increment: err_count becomes 0. clr also clears stuck, but a same-cycle din == 0 sample sets stuck again.
- locked = (state == LOCK), driven from a register.

## Timing
- All outputs are registered. Latency is 1 cycle: the response to the sample taken at edge N appears after edge N.
- locked rises after the edge that samples the LOCK_COUNT-th consecutive match, i.e. the (LOCK_COUNT+1)-th valid sample from IDLE.
- locked falls after the edge that samples a mismatch; err pulses in that same cycle.
- err and period_valid are high for exactly one cycle per event. They are low on cycles where in_valid = 0.
- Reset values: locked=0, err=0, err_count=0, period=0, period_valid=0, stuck=0, state=IDLE.
- rst asserted mid-operation clears everything asynchronously, without waiting for clk. The first valid sample after rst deassertion is treated as the IDLE seed.
- Back-to-back valid samples are accepted every cycle. Gaps in in_valid stretch time but do not change any count.

## Test plan
- Reset, then feed the continuous valid stream 8,4,2,9,C,... -> locked rises after the 9 is sampled; err stays 0. After 15 more samples (din == 9 again), period = 15 and period_valid pulses once. period_valid then repeats every 15 samples.
- Locked stream, then inject 4'h5 where 4'h4 is expected -> err pulses once, err_count = 1, locked drops. Resuming a correct stream from 5 relocks after 3 further matches.
- Sample din = 0 in IDLE and in LOCK -> stuck = 1 stays set and state goes to IDLE. Asserting clr clears stuck and err_count.
- Locked stream with in_valid toggling 1,0,1,0 -> identical lock and period results; no pulses occur on cycles with in_valid = 0.
- Force 256 mismatches with relocks in between -> err_count saturates at 255. clr coincident with a mismatch -> err_count = 0.
- Assert rst between clock edges while locked -> all outputs are 0 before the next edge. Restart from seed 4'h1 locks normally.
